// File: rtl/mem_addr_loader.sv
// mem_addr_loader: memory-side front end for a 16x8 asynchronous SRAM.
// Run mode: holds the MAR and performs bus-to-RAM writes on request.
// Program mode: accepts a byte stream over valid/ready and writes it to
// addresses 0..15 in order. Each write is a setup/strobe/hold sequence so
// the SRAM never sees address or data move while write-enable is low.
module mem_addr_loader (
    input  logic       clk,
    input  logic       reset,
    input  logic       prog_mode,
    input  logic [7:0] bus_in,
    input  logic       mar_in_n,
    input  logic       ram_in_n,
    input  logic [7:0] ld_data,
    input  logic       ld_valid,
    output logic       ld_ready,
    output logic       ld_done,
    output logic       busy,
    output logic [3:0] mem_address,
    output logic [7:0] mem_data,
    output logic       mem_write_enable_n
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t     state_r;
    state_t     state_next_s;
    logic [3:0] mar_r;
    logic [3:0] load_ptr_r;
    logic [3:0] wr_addr_r;
    logic [7:0] wr_data_r;
    logic       done_r;
    logic       prog_wr_r;     // ownership of the write in flight, latched at capture
    logic       we_n_r;
    logic       ld_ready_s;
    logic       start_s;

    // State register: synchronous reset forces IDLE on the next edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: a started write always runs the full three phases.
    always_comb begin
        state_next_s = ST_IDLE;
        if (prog_mode) begin
            start_s = ld_valid & ld_ready_s;
        end else begin
            start_s = ~ram_in_n;
        end
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_next_s = ST_SETUP;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SETUP:  state_next_s = ST_STROBE;
            ST_STROBE: state_next_s = ST_HOLD;
            ST_HOLD:   state_next_s = ST_IDLE;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // Output logic: address mux, handshake and status decode.
    always_comb begin
        ld_ready_s         = prog_mode & (state_r == ST_IDLE) & ~done_r & ~reset;
        ld_ready           = ld_ready_s;
        ld_done            = done_r;
        busy               = (state_r != ST_IDLE);
        mem_data           = wr_data_r;
        mem_write_enable_n = we_n_r;
        mem_address        = mar_r;
        if (state_r != ST_IDLE) begin
            mem_address = wr_addr_r;
        end else if (prog_mode) begin
            mem_address = load_ptr_r;
        end else begin
            mem_address = mar_r;
        end
    end

    // Write-enable flop: low exactly for the cycle spent in STROBE.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_n_r <= 1'b1;
        end else begin
            we_n_r <= (state_next_s != ST_STROBE);
        end
    end

    // MAR: loads from the bus in run mode regardless of write state.
    always_ff @(posedge clk) begin
        if (reset) begin
            mar_r <= 4'd0;
        end else if (!mar_in_n && !prog_mode) begin
            mar_r <= bus_in[3:0];
        end
    end

    // Write capture: address/data frozen from the capture edge until HOLD ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_addr_r <= 4'd0;
            wr_data_r <= 8'd0;
            prog_wr_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && start_s) begin
            prog_wr_r <= prog_mode;
            if (prog_mode) begin
                wr_addr_r <= load_ptr_r;
                wr_data_r <= ld_data;
            end else begin
                wr_addr_r <= mar_r;   // pre-load MAR value on a shared edge
                wr_data_r <= bus_in;
            end
        end
    end

    // Loader pointer and done flag: advance after a program write, clear in run idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_ptr_r <= 4'd0;
            done_r     <= 1'b0;
        end else if ((state_r == ST_HOLD) && prog_wr_r) begin
            load_ptr_r <= load_ptr_r + 4'd1;
            if (wr_addr_r == 4'hF) begin
                done_r <= 1'b1;
            end
        end else if ((state_r == ST_IDLE) && !prog_mode) begin
            load_ptr_r <= 4'd0;
            done_r     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_addr_loader.sv
// Testbench for mem_addr_loader: directed stimulus pushes expected RAM writes
// into a scoreboard queue; a monitor pops and checks on every write strobe,
// including address/data stability in the cycles around the strobe.
module tb_mem_addr_loader;

    logic       clk;
    logic       reset;
    logic       prog_mode;
    logic [7:0] bus_in;
    logic       mar_in_n;
    logic       ram_in_n;
    logic [7:0] ld_data;
    logic       ld_valid;
    logic       ld_ready;
    logic       ld_done;
    logic       busy;
    logic [3:0] mem_address;
    logic [7:0] mem_data;
    logic       mem_write_enable_n;

    int         n_checks;
    int         n_fails;
    logic [11:0] exp_q[$];

    mem_addr_loader dut (
        .clk                (clk),
        .reset              (reset),
        .prog_mode          (prog_mode),
        .bus_in             (bus_in),
        .mar_in_n           (mar_in_n),
        .ram_in_n           (ram_in_n),
        .ld_data            (ld_data),
        .ld_valid           (ld_valid),
        .ld_ready           (ld_ready),
        .ld_done            (ld_done),
        .busy               (busy),
        .mem_address        (mem_address),
        .mem_data           (mem_data),
        .mem_write_enable_n (mem_write_enable_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: checks each strobe and its setup/hold neighbourhood.
    task automatic monitor();
        logic       prev_we_n = 1'b1;
        logic [3:0] prev_addr = 4'd0;
        logic [7:0] prev_data = 8'd0;
        logic       hold_pend = 1'b0;
        logic [3:0] hold_addr = 4'd0;
        logic [7:0] hold_data = 8'd0;
        logic [11:0] e;
        forever begin
            @(negedge clk);
            if (mem_write_enable_n === 1'b0) begin
                chk("we_pulse_width", {7'd0, prev_we_n}, 8'd1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 8'd1, 8'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_addr", {4'd0, mem_address}, {4'd0, e[11:8]});
                    chk("write_data", mem_data, e[7:0]);
                end
                chk("setup_addr", {4'd0, mem_address}, {4'd0, prev_addr});
                chk("setup_data", mem_data, prev_data);
                hold_pend = 1'b1;
                hold_addr = mem_address;
                hold_data = mem_data;
            end else if (hold_pend) begin
                hold_pend = 1'b0;
                if (!reset) begin
                    chk("hold_addr", {4'd0, mem_address}, {4'd0, hold_addr});
                    chk("hold_data", mem_data, hold_data);
                end
            end
            prev_we_n = mem_write_enable_n;
            prev_addr = mem_address;
            prev_data = mem_data;
        end
    endtask

    // Program-mode single byte: wait for ready (bounded), expect write, handshake.
    task automatic send_byte(input logic [3:0] addr, input logic [7:0] data);
        int cnt;
        ld_data  = data;
        ld_valid = 1'b1;
        #1;
        cnt = 0;
        while (!ld_ready && cnt < 10) begin
            tick();
            cnt++;
        end
        if (!ld_ready) chk("ld_ready_timeout", 8'd0, 8'd1);
        exp_q.push_back({addr, data});
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic stimulus();
        int cnt;
        // Reset with random inputs held for two cycles
        reset     = 1'b1;
        prog_mode = 1'($urandom_range(0, 1));
        bus_in    = 8'($urandom);
        mar_in_n  = 1'($urandom_range(0, 1));
        ram_in_n  = 1'($urandom_range(0, 1));
        ld_data   = 8'($urandom);
        ld_valid  = 1'($urandom_range(0, 1));
        tick();
        tick();
        chk("rst_ld_ready", {7'd0, ld_ready}, 8'd0);
        chk("rst_ld_done", {7'd0, ld_done}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_we_n", {7'd0, mem_write_enable_n}, 8'd1);
        chk("rst_mem_data", mem_data, 8'd0);
        chk("rst_mem_address", {4'd0, mem_address}, 8'd0);

        reset     = 1'b0;
        prog_mode = 1'b0;
        mar_in_n  = 1'b1;
        ram_in_n  = 1'b1;
        ld_valid  = 1'b0;
        bus_in    = 8'd0;
        ld_data   = 8'd0;
        tick();

        // Program load: 16 bytes with ld_valid held high
        prog_mode = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ld_data  = 8'h10 + 8'(i);
            ld_valid = 1'b1;
            #1;
            cnt = 0;
            while (!ld_ready && cnt < 10) begin
                tick();
                cnt++;
            end
            if (i > 0) chk("ld_ready_gap", 8'(cnt), 8'd3);
            exp_q.push_back({4'(i), 8'h10 + 8'(i)});
            tick();
        end
        tick();
        tick();
        chk("done_before_end", {7'd0, ld_done}, 8'd0);
        chk("busy_in_hold", {7'd0, busy}, 8'd1);
        tick();
        chk("ld_done_set", {7'd0, ld_done}, 8'd1);
        chk("ready_after_done", {7'd0, ld_ready}, 8'd0);
        chk("busy_after_load", {7'd0, busy}, 8'd0);
        for (int i = 0; i < 8; i++) tick();
        chk("ready_still_low", {7'd0, ld_ready}, 8'd0);
        ld_valid = 1'b0;

        // Run write with simultaneous MAR load
        prog_mode = 1'b0;
        tick();
        mar_in_n = 1'b0;
        bus_in   = 8'h03;
        tick();
        mar_in_n = 1'b1;
        #1;
        chk("mar_load", {4'd0, mem_address}, 8'd3);
        mar_in_n = 1'b0;
        ram_in_n = 1'b0;
        bus_in   = 8'hA7;
        exp_q.push_back({4'd3, 8'hA7});
        tick();
        mar_in_n = 1'b1;
        ram_in_n = 1'b1;
        #1;
        cnt = 0;
        while (busy && cnt < 10) begin
            cnt++;
            tick();
        end
        chk("busy_cycles", 8'(cnt), 8'd3);
        chk("mar_after_write", {4'd0, mem_address}, 8'd7);

        // Requests while busy are dropped
        ram_in_n = 1'b0;
        bus_in   = 8'h5C;
        exp_q.push_back({4'd7, 8'h5C});
        tick();
        bus_in   = 8'hEE;
        ld_valid = 1'b1;
        #1;
        chk("busy_ld_ready", {7'd0, ld_ready}, 8'd0);
        tick();
        tick();
        ram_in_n = 1'b1;
        ld_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("busy_drop_idle", {7'd0, busy}, 8'd0);

        // Mode switch during STROBE of the byte at address 5
        prog_mode = 1'b1;
        for (int i = 0; i < 6; i++) send_byte(4'(i), 8'h40 + 8'(i));
        tick();
        prog_mode = 1'b0;
        tick();
        tick();
        #1;
        chk("switch_busy", {7'd0, busy}, 8'd0);
        chk("switch_run_addr", {4'd0, mem_address}, 8'd7);
        tick();
        prog_mode = 1'b1;
        #1;
        chk("reentry_ptr", {4'd0, mem_address}, 8'd0);
        chk("reentry_ready", {7'd0, ld_ready}, 8'd1);
        send_byte(4'd0, 8'h99);
        for (int i = 0; i < 4; i++) tick();

        // Reset asserted during STROBE
        prog_mode = 1'b0;
        tick();
        mar_in_n = 1'b0;
        bus_in   = 8'h09;
        tick();
        mar_in_n = 1'b1;
        ram_in_n = 1'b0;
        bus_in   = 8'h3E;
        exp_q.push_back({4'd9, 8'h3E});
        tick();
        ram_in_n = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        chk("mid_rst_we_n", {7'd0, mem_write_enable_n}, 8'd1);
        chk("mid_rst_busy", {7'd0, busy}, 8'd0);
        chk("mid_rst_mar", {4'd0, mem_address}, 8'd0);
        chk("mid_rst_data", mem_data, 8'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("post_rst_busy", {7'd0, busy}, 8'd0);
        chk("missing_writes", 8'(exp_q.size()), 8'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        fork
            monitor();
            stimulus();
            begin
                #200000;
                chk("global_timeout", 8'd1, 8'd0);
            end
        join_any
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mem_addr_loader.md
# mem_addr_loader

Memory-side front end for the 16×8 RAM: owns the RAM's address, data and active-low write-enable inputs. Run mode: holds the memory address register (MAR), loaded from the bus, and sequences bus-to-RAM writes. Program mode: accepts a byte stream over a valid/ready handshake and writes it to addresses 0..15 in order. Every write uses a glitch-free three-phase setup/strobe/hold sequence, so the asynchronous SRAM never sees address or data change while write-enable is low.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- prog_mode  in  1  1 = loader owns RAM, 0 = run mode
- bus_in  in  8  system bus value
- mar_in_n  in  1  active-low: load MAR from bus_in[3:0] (run mode)
- ram_in_n  in  1  active-low: request write of bus_in to RAM[MAR] (run mode)
- ld_data  in  8  program byte
- ld_valid  in  1  ld_data valid
- ld_ready  out  1  loader can accept ld_data this cycle
- ld_done  out  1  all 16 program bytes written
- busy  out  1  write sequence in progress
- mem_address  out  4  to RAM address
- mem_data  out  8  to RAM data
- mem_write_enable_n  out  1  to RAM write enable, active-low

## Operation
- Registers: mar[3:0], load_ptr[3:0], wr_addr[3:0], wr_data[7:0], done, state ∈ {IDLE, SETUP, STROBE, HOLD}.
- Reset values: mar=0, load_ptr=0, wr_addr=0, wr_data=0, done=0, state=IDLE. Outputs: ld_ready=0, ld_done=0, busy=0, mem_write_enable_n=1, mem_data=0, mem_address=0.
- mem_address = wr_addr when state≠IDLE; else load_ptr if prog_mode; else mar.
- mem_data = wr_data at all times.
- mem_write_enable_n comes from a flop; it is 0 only during STROBE.
- busy = (state≠IDLE). ld_ready = prog_mode & state==IDLE & ~done & ~reset. ld_done = done.
- MAR: loads bus_in[3:0] on any edge where mar_in_n=0 and prog_mode=0, regardless of state. It holds in prog_mode.
- IDLE, prog_mode=1: on ld_valid & ld_ready, capture wr_addr←load_ptr and wr_data←ld_data, then go to SETUP.
- IDLE, prog_mode=0: on ram_in_n=0, capture wr_addr←mar (value before any same-edge MAR load) and wr_data←bus_in, then go to SETUP.
- SETUP → STROBE → HOLD → IDLE unconditionally.
- Leaving HOLD for a program-mode write: load_ptr increments (mod 16). If the write was to address 15, set done.
- Program-mode ownership is latched at capture, so a prog_mode change during SETUP/STROBE/HOLD does not abort or retarget the write.
- In IDLE with prog_mode=0, load_ptr←0 and done←0, so re-entering prog_mode restarts at address 0.
- While done=1 and prog_mode=1, ld_ready=0 and ld_valid is ignored.
- Inputs ram_in_n, ld_valid and mar_in_n are sampled only as above. Requests arriving while busy are dropped, not queued. The upstream sequencer must hold ram_in_n until busy has been seen low.

## Timing
- Handshake accepted on edge E0, then:
  - E0→E1: SETUP, we_n=1, address/data stable
  - E1→E2: STROBE, we_n=0
  - E2→E3: HOLD, we_n=1
  - back in IDLE after E3; ld_ready is high again in the cycle after E3 (if not done)
- Throughput: one write per 4 cycles. Full 16-byte load takes ≥64 cycles.
- mem_address and mem_data are constant from the capture edge through the end of HOLD.
- ld_done rises in the cycle after the HOLD of the address-15 write.
- MAR load latency: 1 edge. mem_address reflects new MAR in the next cycle when idle in run mode.
- Reset asserted mid-sequence: the next edge forces IDLE and we_n=1. A partially strobed write is abandoned with no further strobe.

## Test plan
- Reset: hold reset 2 cycles with random inputs → all outputs at listed reset values; we_n=1 throughout.
- Program load: prog_mode=1, stream ld_data=0x10+i for i=0..15 with ld_valid held high → exactly 16 one-cycle we_n pulses at mem_address 0..15 with data 0x10..0x1F. Address/data stable one cycle before and after each pulse. ld_done=1 after the last; ld_ready=0 thereafter.
- Run write with simultaneous MAR load: mar=3; same edge mar_in_n=0, ram_in_n=0, bus_in=0xA7 → write of 0xA7 to address 3, mar=7 afterwards, busy high 3 cycles.
- Requests while busy: pulse ram_in_n and ld_valid during SETUP/STROBE → no extra write, no handshake accepted.
- Mode switch: drop prog_mode during STROBE of the byte at address 5 → write completes at 5. load_ptr increments, then clears to 0 in the first idle run-mode cycle. Re-entering prog_mode → next byte lands at address 0.
- Reset mid-write: assert reset in STROBE → we_n=1 on the next edge, state IDLE, no further we_n pulse, mar=0.
